// File: rtl/se_global_avg_pool_pkg.sv
// Shared SE definitions: pooling FSM states, reciprocal constant and signed saturation,
// reused by the squeeze, excite and scale stages.
package se_global_avg_pool_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } se_pool_state_t;

    // round(2^shift / npix) using integer arithmetic only, so it folds at elaboration
    function automatic int recip_const(input int npix, input int shift);
        return ((32'sd1 <<< shift) + npix / 2) / npix;
    endfunction

    function automatic longint sat_signed(input longint value, input int width);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/se_recip_scale.sv
// Registered sum * reciprocal, floor shift and saturate; one cycle latency, no backpressure.
// out_dat holds its last value when no beat is presented.
module se_recip_scale
    import se_global_avg_pool_pkg::*;
#(
    parameter int ACC_W       = 23,
    parameter int DATA_WIDTH  = 16,
    parameter int RECIP       = 1337,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic                         in_last,
    input  logic signed [ACC_W-1:0]      in_dat,
    output logic                         out_vld,
    output logic                         out_last,
    output logic signed [DATA_WIDTH-1:0] out_dat
);

    localparam int RECIP_W = RECIP_SHIFT + 1;
    localparam int PROD_W  = ACC_W + RECIP_W;
    localparam logic signed [RECIP_W-1:0] RECIP_C = RECIP_W'(RECIP);

    logic signed [PROD_W-1:0]     prod;
    logic signed [PROD_W-1:0]     shifted;
    logic                         out_vld_q, out_vld_d;
    logic                         out_last_q, out_last_d;
    logic signed [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

    always_comb begin
        prod       = PROD_W'(in_dat) * PROD_W'(RECIP_C);
        // arithmetic shift floors toward -inf, matching the average rounding rule
        shifted    = prod >>> RECIP_SHIFT;
        out_vld_d  = in_vld;
        out_last_d = in_vld && in_last;
        out_dat_d  = out_dat_q;
        if (in_vld) begin
            out_dat_d = DATA_WIDTH'(sat_signed(64'(shifted), DATA_WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_dat_q  <= out_dat_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign out_dat  = out_dat_q;

endmodule

// File: rtl/se_global_avg_pool.sv
// SE squeeze: per-channel sum over HEIGHT*WIDTH pixels, then serial scaled averages 2 cycles
// after the last element; input stalls (in_ready=0) for the CHANNELS-cycle drain, output never stalls.
module se_global_avg_pool
    import se_global_avg_pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 16,
    parameter int HEIGHT      = 7,
    parameter int WIDTH       = 7,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         busy
);

    localparam int NPIX  = HEIGHT * WIDTH;
    localparam int ACC_W = DATA_WIDTH + $clog2(NPIX) + 1;
    localparam int RECIP = recip_const(NPIX, RECIP_SHIFT);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

    se_pool_state_t          state_q, state_d;
    logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
    logic [CH_W-1:0]         rd_idx_q, rd_idx_d;
    logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic signed [ACC_W-1:0] acc_q [CHANNELS];
    logic signed [ACC_W-1:0] acc_d [CHANNELS];
    logic                    rd_vld_q, rd_vld_d;
    logic                    rd_last_q, rd_last_d;
    logic signed [ACC_W-1:0] rd_dat_q, rd_dat_d;
    logic                    xfer;
    logic                    frame_done;
    logic                    drain_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    assign xfer       = in_valid && in_ready;
    assign frame_done = xfer && (ch_cnt_q == CH_LAST) && (pix_cnt_q == PIX_LAST);
    assign drain_done = (state_q == DRAIN) && (rd_idx_q == CH_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (frame_done) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ACCUM);
        busy     = (state_q == DRAIN) || (ch_cnt_q != '0) || (pix_cnt_q != '0);
    end

    always_comb begin
        ch_cnt_d  = ch_cnt_q;
        pix_cnt_d = pix_cnt_q;
        rd_idx_d  = rd_idx_q;
        acc_d     = acc_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        rd_dat_d  = rd_dat_q;
        if (xfer) begin
            acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + ACC_W'(in_data);
            if (ch_cnt_q == CH_LAST) begin
                ch_cnt_d  = '0;
                pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
            end else begin
                ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
            if (frame_done) rd_idx_d = '0;
        end
        // each sum is cleared as it is read so the next frame starts from zero
        if (state_q == DRAIN) begin
            rd_vld_d        = 1'b1;
            rd_last_d       = (rd_idx_q == CH_LAST);
            rd_dat_d        = acc_q[rd_idx_q];
            acc_d[rd_idx_q] = '0;
            rd_idx_d        = drain_done ? '0 : rd_idx_q + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q  <= '0;
            pix_cnt_q <= '0;
            rd_idx_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_dat_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
        end else begin
            ch_cnt_q  <= ch_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            rd_idx_q  <= rd_idx_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            rd_dat_q  <= rd_dat_d;
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
        end
    end

    se_recip_scale #(
        .ACC_W       (ACC_W),
        .DATA_WIDTH  (DATA_WIDTH),
        .RECIP       (RECIP),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_scale (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_vld_q),
        .in_last  (rd_last_q),
        .in_dat   (rd_dat_q),
        .out_vld  (out_valid),
        .out_last (out_last),
        .out_dat  (out_data)
    );

endmodule
